sr04_echo_emulator: RTL and testbench

Behavioural responder for the HC-SR04 ultrasonic link: samples the `trigger` line driven by the range-finder controller and answers with an `echo` pulse whose width encodes a programmed distance at 58 us/cm. It replaces the physical sensor in simulation and FPGA loop-back builds, so the controller and distance path can be exercised without hardware. It is synthesizable, runs on the system clock and derives its own 1 us time base.

---
 rtl/sr04_echo_emulator.sv | 200 ++++++++++++++++++++
 tb/tb_sr04_echo_emulator.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sr04_echo_emulator.sv
// ---------------------------------------------------------------------------
// sr04_echo_emulator
//
// Behavioural stand-in for an HC-SR04 ultrasonic sensor. It watches the
// trigger line from a range-finder controller and answers with an echo pulse
// whose width encodes a programmed distance (US_PER_CM ticks per cm). A 1 us
// tick is derived from the system clock, and all echo timing is tick-aligned.
//
// Sequence: IDLE -> TRIG (measure trigger width) -> BURST (emulated 8x40 kHz
// burst delay) -> ECHO (echo high) -> HOLDOFF (dead time) -> IDLE.
//
// Ports
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   enable     in   when low, new triggers are ignored in IDLE
//   trigger    in   trigger from the controller (same clock domain)
//   dist_cm    in   [9:0] simulated distance, latched when a trigger is accepted
//   echo       out  echo pulse (registered)
//   busy       out  high in every state except IDLE (registered)
//   trig_err   out  one-clock pulse when a trigger is too short (registered)
//   dbg_state  out  [2:0] current FSM state, for observation only
// ---------------------------------------------------------------------------
module sr04_echo_emulator #(
    parameter int F_COUNT        = 100,
    parameter int MIN_TRIG_TICKS = 9,
    parameter int BURST_US       = 200,
    parameter int US_PER_CM      = 58,
    parameter int MAX_CM         = 400,
    parameter int TIMEOUT_US     = 38000,
    parameter int HOLDOFF_US     = 10000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       trigger,
    input  logic [9:0] dist_cm,
    output logic       echo,
    output logic       busy,
    output logic       trig_err,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_TRIG    = 3'd1,
        S_BURST   = 3'd2,
        S_ECHO    = 3'd3,
        S_HOLDOFF = 3'd4
    } state_t;

    localparam int TW = (F_COUNT > 1) ? $clog2(F_COUNT) : 1;

    localparam logic [TW-1:0] TICK_LAST    = TW'(F_COUNT - 1);
    localparam logic [15:0]   MIN_TRIG_W   = 16'(MIN_TRIG_TICKS);
    localparam logic [15:0]   BURST_LAST   = 16'(BURST_US - 1);
    localparam logic [15:0]   HOLDOFF_LAST = 16'(HOLDOFF_US - 1);
    localparam logic [15:0]   US_PER_CM_W  = 16'(US_PER_CM);
    localparam logic [15:0]   MAX_CM_W     = 16'(MAX_CM);
    localparam logic [15:0]   TIMEOUT_W    = 16'(TIMEOUT_US);

    // -----------------------------------------------------------------------
    // 1 us time base: free-running, not restarted by trigger activity, so
    // echo edges always land on tick edges.
    // -----------------------------------------------------------------------
    logic [TW-1:0] tcnt_q;
    logic          tick;

    assign tick = (tcnt_q == TICK_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt_q <= '0;
        end else if (tick) begin
            tcnt_q <= '0;
        end else begin
            tcnt_q <= tcnt_q + TW'(1);
        end
    end

    // -----------------------------------------------------------------------
    // Echo length for the current dist_cm, captured only on acceptance.
    // Zero distance still produces a visible 1-tick echo.
    // -----------------------------------------------------------------------
    logic [15:0] echo_len_d;

    always_comb begin
        echo_len_d = 16'(dist_cm) * US_PER_CM_W;
        if (16'(dist_cm) > MAX_CM_W) begin
            echo_len_d = TIMEOUT_W;
        end else if (dist_cm == 10'd0) begin
            echo_len_d = 16'd1;
        end
    end

    // -----------------------------------------------------------------------
    // Main FSM with registered outputs.
    // -----------------------------------------------------------------------
    state_t      state_q;
    logic        trig_prev_q;
    logic [15:0] hcnt_q;
    logic [15:0] wcnt_q;
    logic [15:0] echo_len_q;
    logic        echo_q;
    logic        busy_q;
    logic        trig_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            trig_prev_q <= 1'b0;
            hcnt_q      <= '0;
            wcnt_q      <= '0;
            echo_len_q  <= '0;
            echo_q      <= 1'b0;
            busy_q      <= 1'b0;
            trig_err_q  <= 1'b0;
        end else begin
            trig_prev_q <= trigger;
            trig_err_q  <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    // Rising-edge test: a level held high through HOLDOFF
                    // must not start another measurement.
                    if (enable && trigger && !trig_prev_q) begin
                        state_q <= S_TRIG;
                        hcnt_q  <= '0;
                        busy_q  <= 1'b1;
                    end
                end

                S_TRIG: begin
                    // The fall is acted on at any clock; the width is only
                    // measured in whole ticks.
                    if (!trigger) begin
                        if (hcnt_q >= MIN_TRIG_W) begin
                            echo_len_q <= echo_len_d;
                            wcnt_q     <= '0;
                            state_q    <= S_BURST;
                        end else begin
                            trig_err_q <= 1'b1;
                            busy_q     <= 1'b0;
                            state_q    <= S_IDLE;
                        end
                    end else if (tick && (hcnt_q < MIN_TRIG_W)) begin
                        hcnt_q <= hcnt_q + 16'd1;
                    end
                end

                S_BURST: begin
                    if (tick) begin
                        if (wcnt_q == BURST_LAST) begin
                            echo_q  <= 1'b1;
                            wcnt_q  <= '0;
                            state_q <= S_ECHO;
                        end else begin
                            wcnt_q <= wcnt_q + 16'd1;
                        end
                    end
                end

                S_ECHO: begin
                    if (tick) begin
                        if (wcnt_q == (echo_len_q - 16'd1)) begin
                            echo_q  <= 1'b0;
                            wcnt_q  <= '0;
                            state_q <= S_HOLDOFF;
                        end else begin
                            wcnt_q <= wcnt_q + 16'd1;
                        end
                    end
                end

                S_HOLDOFF: begin
                    if (tick) begin
                        if (wcnt_q == HOLDOFF_LAST) begin
                            wcnt_q  <= '0;
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end else begin
                            wcnt_q <= wcnt_q + 16'd1;
                        end
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    echo_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign echo      = echo_q;
    assign busy      = busy_q;
    assign trig_err  = trig_err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_sr04_echo_emulator.sv
// ---------------------------------------------------------------------------
// tb_sr04_echo_emulator
//
// Self-checking bench for sr04_echo_emulator. Timing parameters are scaled
// down (5 clocks per tick, short burst/holdoff/timeout) so every scenario
// fits in a short run; the distance scale stays at 58 ticks per cm.
// Inputs change 1 time unit after a rising edge; outputs are read either at
// that same point or on the falling edge by the echo monitor.
// ---------------------------------------------------------------------------
module tb_sr04_echo_emulator;

    localparam int TB_F     = 5;
    localparam int TB_MIN   = 9;
    localparam int TB_BURST = 20;
    localparam int TB_UPC   = 58;
    localparam int TB_MAX   = 40;
    localparam int TB_TO    = 3000;
    localparam int TB_HOLD  = 100;

    localparam int DELAY_LO = (TB_BURST - 1) * TB_F + 1;
    localparam int DELAY_HI = TB_BURST * TB_F;

    // Clock / reset / DUT signals
    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       trigger;
    logic [9:0] dist_cm;
    logic       echo;
    logic       busy;
    logic       trig_err;
    logic [2:0] dbg_state;

    // Bookkeeping
    int checks = 0;
    int errors = 0;
    logic [31:0] cyc_cnt = '0;
    logic [31:0] last_acc;

    // Scoreboard: expected echo widths (clocks) and acceptance edges (cycle)
    logic [31:0] exp_q[$];
    logic [31:0] acc_q[$];

    sr04_echo_emulator #(
        .F_COUNT        (TB_F),
        .MIN_TRIG_TICKS (TB_MIN),
        .BURST_US       (TB_BURST),
        .US_PER_CM      (TB_UPC),
        .MAX_CM         (TB_MAX),
        .TIMEOUT_US     (TB_TO),
        .HOLDOFF_US     (TB_HOLD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .trigger   (trigger),
        .dist_cm   (dist_cm),
        .echo      (echo),
        .busy      (busy),
        .trig_err  (trig_err),
        .dbg_state (dbg_state)
    );

    // -----------------------------------------------------------------------
    // Clock
    // -----------------------------------------------------------------------
    initial begin
        forever #5 clk = ~clk;
    end

    // -----------------------------------------------------------------------
    // Reference model of the echo width in clocks
    // -----------------------------------------------------------------------
    function automatic logic [31:0] exp_clks(input int d);
        int t;
        if (d > TB_MAX) t = TB_TO;
        else if (d == 0) t = 1;
        else t = d * TB_UPC;
        return 32'(t * TB_F);
    endfunction

    // -----------------------------------------------------------------------
    // Driver tasks
    // -----------------------------------------------------------------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Trigger high for hi_clks sampled edges; last_acc is the edge that
    // samples the fall.
    task automatic drive_trigger(input int hi_clks);
        trigger = 1'b1;
        cyc(hi_clks);
        trigger = 1'b0;
        last_acc = cyc_cnt + 32'd1;
    endtask

    task automatic send_accepted(input int d);
        dist_cm = 10'(d);
        exp_q.push_back(exp_clks(d));
        drive_trigger(12 * TB_F);
        acc_q.push_back(last_acc);
    endtask

    task automatic wait_echo(input logic level, input int budget, output bit ok);
        int n;
        n = 0;
        while (echo !== level && n < budget) begin
            cyc(1);
            n++;
        end
        ok = (echo === level);
    endtask

    task automatic wait_busy(input logic level, input int budget, output bit ok);
        int n;
        n = 0;
        while (busy !== level && n < budget) begin
            cyc(1);
            n++;
        end
        ok = (busy === level);
    endtask

    // -----------------------------------------------------------------------
    // Background processes: cycle counter, echo monitor, watchdog
    // -----------------------------------------------------------------------
    task automatic count_cycles();
        forever begin
            @(posedge clk);
            cyc_cnt = cyc_cnt + 32'd1;
        end
    endtask

    task automatic echo_monitor();
        bit          in_pulse;
        logic [31:0] width;
        logic [31:0] acc;
        logic [31:0] delay;
        logic [31:0] exp;
        in_pulse = 1'b0;
        width    = '0;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                in_pulse = 1'b0;
            end else if (echo === 1'b1 && !in_pulse) begin
                in_pulse = 1'b1;
                width    = 32'd1;
                checks++;
                if (acc_q.size() == 0) begin
                    errors++;
                    $display("FAIL echo_unexpected_rise: echo rose at cycle %0d with nothing expected", cyc_cnt);
                end else begin
                    acc   = acc_q.pop_front();
                    delay = cyc_cnt - acc;
                    if (delay < 32'(DELAY_LO) || delay > 32'(DELAY_HI)) begin
                        errors++;
                        $display("FAIL echo_delay: got %0d clocks, expected %0d..%0d", delay, DELAY_LO, DELAY_HI);
                    end
                end
            end else if (echo === 1'b1) begin
                width = width + 32'd1;
            end else if (in_pulse) begin
                in_pulse = 1'b0;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL echo_width: pulse of %0d clocks with no expected width", width);
                end else begin
                    exp = exp_q.pop_front();
                    if (width !== exp) begin
                        errors++;
                        $display("FAIL echo_width: got %0d clocks, expected %0d", width, exp);
                    end
                end
            end
        end
    endtask

    // -----------------------------------------------------------------------
    // Scenario tasks
    // -----------------------------------------------------------------------
    task automatic test_reset();
        int bad;
        rst = 1'b1;
        cyc(3);
        checks++;
        if (echo !== 1'b0) begin errors++; $display("FAIL reset_echo: got %b expected 0", echo); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++;
        if (trig_err !== 1'b0) begin errors++; $display("FAIL reset_trig_err: got %b expected 0", trig_err); end
        checks++;
        if (dbg_state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            cyc(1);
            if (echo !== 1'b0 || busy !== 1'b0 || trig_err !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL idle_quiet: %0d active samples, expected 0", bad); end
    endtask

    task automatic test_basic();
        bit ok;
        int n;
        dist_cm = 10'd10;
        exp_q.push_back(exp_clks(10));
        trigger = 1'b1;
        cyc(1);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL busy_rise: got %b expected 1", busy); end
        cyc(12 * TB_F - 1);
        trigger = 1'b0;
        acc_q.push_back(cyc_cnt + 32'd1);
        cyc(1);
        checks++;
        if (trig_err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL accept_flags: trig_err %b busy %b, expected 0 1", trig_err, busy);
        end
        wait_echo(1'b1, 2 * DELAY_HI, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL basic_echo_rise: echo %b expected 1 within budget", echo); end
        wait_echo(1'b0, exp_clks(10) + 50, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL basic_echo_fall: echo %b expected 0 within budget", echo); end
        n = 0;
        while (busy === 1'b1 && n < 4 * TB_HOLD * TB_F) begin
            cyc(1);
            n++;
        end
        checks++;
        if (n != TB_HOLD * TB_F) begin
            errors++;
            $display("FAIL holdoff_len: busy high %0d clocks after echo, expected %0d", n, TB_HOLD * TB_F);
        end
    endtask

    task automatic test_short();
        int lens[3] = '{25, 40, 2};
        bit ok;
        dist_cm = 10'd10;
        foreach (lens[k]) begin
            cyc(3);
            drive_trigger(lens[k]);
            cyc(1);
            checks++;
            if (trig_err !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL short_reject_%0d: trig_err %b busy %b, expected 1 0", lens[k], trig_err, busy);
            end
            cyc(1);
            checks++;
            if (trig_err !== 1'b0) begin
                errors++;
                $display("FAIL trig_err_width_%0d: got %b expected 0", lens[k], trig_err);
            end
        end
        // A nominal 10 us pulse must be accepted whatever the tick phase.
        cyc(3);
        dist_cm = 10'd1;
        exp_q.push_back(exp_clks(1));
        drive_trigger(10 * TB_F);
        acc_q.push_back(last_acc);
        cyc(1);
        checks++;
        if (trig_err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL min_accept: trig_err %b busy %b, expected 0 1", trig_err, busy);
        end
        wait_busy(1'b0, 20000, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL min_accept_done: busy %b expected 0", busy); end
    endtask

    task automatic test_range();
        int dists[3] = '{41, 40, 0};
        bit ok;
        foreach (dists[k]) begin
            cyc(3);
            send_accepted(dists[k]);
            wait_busy(1'b0, 40000, ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL range_done_%0d: busy %b expected 0", dists[k], busy); end
        end
    endtask

    task automatic test_retrigger();
        bit ok;
        cyc(3);
        send_accepted(10);
        wait_echo(1'b1, 2 * DELAY_HI, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL retrig_rise: echo %b expected 1", echo); end
        cyc(100);
        dist_cm = 10'd41;
        drive_trigger(12 * TB_F);
        cyc(1);
        checks++;
        if (busy !== 1'b1 || trig_err !== 1'b0 || echo !== 1'b1) begin
            errors++;
            $display("FAIL retrig_in_echo: busy %b trig_err %b echo %b, expected 1 0 1", busy, trig_err, echo);
        end
        wait_echo(1'b0, exp_clks(10), ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL retrig_fall: echo %b expected 0", echo); end
        // Hold trigger high across the end of HOLDOFF: no edge, no start.
        cyc(20);
        trigger = 1'b1;
        wait_busy(1'b0, 4 * TB_HOLD * TB_F, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL retrig_idle: busy %b expected 0", busy); end
        cyc(50);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL held_level: busy %b expected 0", busy); end
        trigger = 1'b0;
        cyc(5);
        send_accepted(2);
        wait_busy(1'b0, 20000, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL clean_after: busy %b expected 0", busy); end
    endtask

    task automatic test_reset_mid_echo();
        bit ok;
        logic [31:0] dropped;
        cyc(3);
        send_accepted(10);
        wait_echo(1'b1, 2 * DELAY_HI, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL mid_rise: echo %b expected 1", echo); end
        cyc(100);
        rst = 1'b1;
        dropped = exp_q.pop_front();
        cyc(1);
        checks++;
        if (echo !== 1'b0 || busy !== 1'b0 || dbg_state !== 3'd0) begin
            errors++;
            $display("FAIL mid_reset: echo %b busy %b state %0d, expected 0 0 0", echo, busy, dbg_state);
        end
        rst = 1'b0;
        cyc(5);
        send_accepted(3);
        wait_busy(1'b0, 20000, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL after_reset_done: busy %b expected 0", busy); end
        enable = 1'b0;
        cyc(3);
        drive_trigger(12 * TB_F);
        cyc(1);
        checks++;
        if (busy !== 1'b0 || trig_err !== 1'b0) begin
            errors++;
            $display("FAIL disabled: busy %b trig_err %b, expected 0 0", busy, trig_err);
        end
        cyc(3 * DELAY_HI);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL disabled_late: busy %b expected 0", busy); end
        enable = 1'b1;
    endtask

    // -----------------------------------------------------------------------
    // Main sequence and report
    // -----------------------------------------------------------------------
    initial begin
        rst     = 1'b1;
        enable  = 1'b1;
        trigger = 1'b0;
        dist_cm = '0;
        fork
            count_cycles();
            echo_monitor();
            begin
                #1500000;
                $display("FAIL watchdog: run did not complete, checks %0d errors %0d", checks, errors);
                $fatal(1, "watchdog expired");
            end
        join_none

        test_reset();
        test_basic();
        test_short();
        test_range();
        test_retrigger();
        test_reset_mid_echo();

        cyc(20);
        checks++;
        if (exp_q.size() != 0 || acc_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d widths and %0d rises outstanding, expected 0 0",
                     exp_q.size(), acc_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
